// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Parametrised register file with an in-flight destination scoreboard.
//   A reset starts a sweep that writes each register with its own index,
//   one register per clock. Reads are allowed only once the sweep has
//   finished. Each register has a pending bit: a multi-cycle unit sets it
//   at issue (alloc) and its writeback clears it.
//
// Configuration macro:
//   REGFILE_BYPASS_EN - when defined, a write in the current cycle is
//                       forwarded to any read port that reads the same
//                       register, and that port reports ready.
//
// Parameters:
//   DATA_W   - register width in bits
//   ADDR_W   - address width; DEPTH = 2**ADDR_W registers
//   ZERO_REG - 1: register 0 always reads 0 and ignores writes and allocs
//
// Ports:
//   clock                 rising-edge clock
//   reset                 synchronous active-high; restarts the init sweep
//   read_reg_1/2          read addresses
//   read_data1/2          combinational read data (0 while busy)
//   read_ready1/2         1 when the addressed register is not pending
//   write_reg/write_data  write port; the write happens when regwrite is 1
//   alloc_valid/alloc_reg sets the pending bit of alloc_reg
//   busy                  1 while the init sweep is running
//   pending_vec           scoreboard; bit i is 1 when register i is pending
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        read_reg_1,
  output logic [DATA_W-1:0]        read_data1,
  output logic                     read_ready1,
  input  logic [ADDR_W-1:0]        read_reg_2,
  output logic [DATA_W-1:0]        read_data2,
  output logic                     read_ready2,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     regwrite,
  input  logic                     alloc_valid,
  input  logic [ADDR_W-1:0]        alloc_reg,
  output logic                     busy,
  output logic [(1<<ADDR_W)-1:0]   pending_vec
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  // The sweep counter has one extra bit. The last index is compared
  // exactly, so the counter never wraps into an illegal address.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_reg;
  logic [ADDR_W:0]     cnt_reg;
  logic [DEPTH-1:0]    pending_reg;
  logic [DEPTH-1:0]    pending_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   init_word;
  logic                write_legal;
  logic                alloc_legal;

  // Writes and allocs take effect only in RUN. With ZERO_REG set they are
  // dropped for register 0.
  assign write_legal = (state_reg == ST_RUN) && regwrite &&
                       ((write_reg != '0) || !ZR);
  assign alloc_legal = (state_reg == ST_RUN) && alloc_valid &&
                       ((alloc_reg != '0) || !ZR);

  // The sweep value is the counter, zero-extended or truncated to DATA_W.
  // Each bit is selected at elaboration, so no index falls out of range.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_init_word
      if (gi <= ADDR_W) begin : g_cnt_bit
        assign init_word[gi] = cnt_reg[gi];
      end else begin : g_zero_bit
        assign init_word[gi] = 1'b0;
      end
    end
  endgenerate

  // Control FSM: the sweep counter and the INIT -> RUN hand-off.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt_reg <= cnt_reg;
        end
        default: begin
          state_reg <= ST_INIT;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Storage array. This block has no reset, so the array can map onto
  // memory. The sweep and normal writes share the single write port.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_reg == ST_INIT) begin
        mem[cnt_reg[ADDR_W-1:0]] <= init_word;
      end else if (write_legal) begin
        mem[write_reg] <= write_data;
      end
    end
  end

  // Scoreboard. The alloc is applied after the clear, so an alloc and a
  // write to the same register in one cycle leave its pending bit set.
  always_comb begin
    pending_next = pending_reg;
    if (write_legal) begin
      pending_next[write_reg] = 1'b0;
    end
    if (alloc_legal) begin
      pending_next[alloc_reg] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // Two identical combinational read ports.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              ready;

      assign addr = (gi == 0) ? read_reg_1 : read_reg_2;

      always_comb begin
        data  = '0;
        ready = 1'b0;
        if (state_reg == ST_RUN) begin
          if (ZR && (addr == '0)) begin
            // A hardwired zero register is never pending and never forwarded.
            ready = 1'b1;
          end else if (BYPASS && write_legal && (write_reg == addr)) begin
            // A writeback in this cycle unblocks a pending reader at once.
            data  = write_data;
            ready = 1'b1;
          end else begin
            data  = mem[addr];
            ready = ~pending_reg[addr];
          end
        end
      end
    end
  endgenerate

  assign read_data1  = g_rd[0].data;
  assign read_ready1 = g_rd[0].ready;
  assign read_data2  = g_rd[1].data;
  assign read_ready2 = g_rd[1].ready;

  assign busy        = (state_reg == ST_INIT);
  assign pending_vec = (state_reg == ST_RUN) ? pending_reg : '0;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//   Self-checking bench for regfile_sb with default parameters. The
//   reference model holds the register contents in a plain array, the
//   pending flags in a bit array, and the sweep progress as an integer.
//   It applies the block's rules once per clock edge.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int ZR    = 1;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [AW-1:0]    read_reg_1, read_reg_2, write_reg, alloc_reg;
  logic [DW-1:0]    read_data1, read_data2, write_data;
  logic             read_ready1, read_ready2, regwrite, alloc_valid, busy;
  logic [DEPTH-1:0] pending_vec;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
    .clock(clock), .reset(reset),
    .read_reg_1(read_reg_1), .read_data1(read_data1), .read_ready1(read_ready1),
    .read_reg_2(read_reg_2), .read_data2(read_data2), .read_ready2(read_ready2),
    .write_reg(write_reg), .write_data(write_data), .regwrite(regwrite),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
    .busy(busy), .pending_vec(pending_vec)
  );

  always #5 clock = ~clock;

  // Reference model state.
  bit          m_run;
  int          m_cnt;
  logic [31:0] m_mem [DEPTH];
  bit          m_pend [DEPTH];

  int n_pass  = 0;
  int n_total = 0;

  function automatic bit legal(input logic [AW-1:0] a);
    return (a != 0) || (ZR == 0);
  endfunction

  function automatic bit fwd(input logic [AW-1:0] a);
    return BYP && regwrite && legal(write_reg) && (write_reg == a);
  endfunction

  function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
    if (!m_run) return 32'h0;
    if (ZR != 0 && a == 0) return 32'h0;
    if (fwd(a)) return write_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_ready(input logic [AW-1:0] a);
    if (!m_run) return 1'b0;
    if (ZR != 0 && a == 0) return 1'b1;
    if (fwd(a)) return 1'b1;
    return !m_pend[a];
  endfunction

  function automatic logic [DEPTH-1:0] exp_pvec();
    logic [DEPTH-1:0] v = '0;
    if (m_run) for (int i = 0; i < DEPTH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Applies one rising edge to the model, using the inputs applied at that edge.
  task automatic model_edge();
    if (reset) begin
      m_run = 0;
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_pend[i] = 0;
    end else if (!m_run) begin
      m_mem[m_cnt] = 32'(m_cnt);
      m_cnt++;
      if (m_cnt == DEPTH) m_run = 1;
    end else begin
      if (regwrite && legal(write_reg)) begin
        m_mem[write_reg]  = write_data;
        m_pend[write_reg] = 0;
      end
      if (alloc_valid && legal(alloc_reg)) m_pend[alloc_reg] = 1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Waits for the outputs to settle, then compares them all with the model.
  task automatic check_all(input string tag);
    #1;
    check({tag, ".busy"},   64'(busy),        64'(!m_run));
    check({tag, ".pvec"},   64'(pending_vec), 64'(exp_pvec()));
    check({tag, ".data1"},  64'(read_data1),  64'(exp_data(read_reg_1)));
    check({tag, ".data2"},  64'(read_data2),  64'(exp_data(read_reg_2)));
    check({tag, ".ready1"}, 64'(read_ready1), 64'(exp_ready(read_reg_1)));
    check({tag, ".ready2"}, 64'(read_ready2), 64'(exp_ready(read_reg_2)));
  endtask

  initial begin
    reset = 1; regwrite = 0; alloc_valid = 0;
    read_reg_1 = 0; read_reg_2 = 0; write_reg = 0; alloc_reg = 0; write_data = 0;
    m_run = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_pend[i] = 0; end

    // Hold reset for two cycles.
    tick(); tick();
    check_all("reset");
    check("reset_busy", 64'(busy), 64'd1);

    // Sweep, with a write to reg 3 and an alloc of reg 4 that must be ignored.
    reset = 0;
    regwrite = 1; write_reg = 3; write_data = 32'hFFFF;
    alloc_valid = 1; alloc_reg = 4;
    for (int i = 0; i < DEPTH; i++) begin
      check_all("sweep");
      tick();
    end
    regwrite = 0; alloc_valid = 0;
    read_reg_1 = 10; read_reg_2 = 31;
    check_all("post_sweep");
    check("busy_done", 64'(busy), 64'd0);
    check("rd10", 64'(read_data1), 64'h0000000A);
    check("rd31", 64'(read_data2), 64'h0000001F);
    read_reg_1 = 3;
    #1;
    check("init_ignored_w3", 64'(read_data1), 64'h3);
    check("init_ignored_pv", 64'(pending_vec), 64'h0);

    // A write to register 0 is dropped.
    regwrite = 1; write_reg = 0; write_data = 32'hDEADBEEF; read_reg_1 = 0;
    check_all("w0_same");
    tick();
    regwrite = 0;
    check_all("w0_next");
    check("r0_data", 64'(read_data1), 64'h0);
    check("r0_ready", 64'(read_ready1), 64'h1);

    // A write to reg 7 while reg 7 is being read.
    regwrite = 1; write_reg = 7; write_data = 32'h12345678; read_reg_1 = 7;
    #1;
    check("w7_same", 64'(read_data1), BYP ? 64'h12345678 : 64'h7);
    check_all("w7_same");
    tick();
    regwrite = 0;
    check("w7_next", 64'(read_data1), 64'h12345678);

    // Scoreboard: alloc, then writeback, then alloc and write in the same cycle.
    read_reg_1 = 5; read_reg_2 = 5;
    alloc_valid = 1; alloc_reg = 5;
    tick();
    alloc_valid = 0;
    check_all("alloc5");
    check("alloc5_ready", 64'(read_ready1), 64'h0);
    check("alloc5_pv", 64'(pending_vec[5]), 64'h1);
    regwrite = 1; write_reg = 5; write_data = 32'hA5A5_0005;
    tick();
    regwrite = 0;
    check_all("wb5");
    check("wb5_ready", 64'(read_ready1), 64'h1);
    regwrite = 1; write_reg = 5; write_data = 32'h0BAD_F00D;
    alloc_valid = 1; alloc_reg = 5;
    tick();
    regwrite = 0; alloc_valid = 0;
    check_all("both5");
    check("both5_pv", 64'(pending_vec[5]), 64'h1);
    check("both5_data", 64'(read_data2), 64'h0BAD_F00D);

    // Random traffic, with an occasional reset.
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 149) == 0);
      regwrite    = $urandom_range(0, 1);
      alloc_valid = ($urandom_range(0, 2) == 0);
      write_reg   = AW'($urandom_range(0, 7));
      alloc_reg   = AW'($urandom_range(0, 7));
      write_data  = $urandom;
      read_reg_1  = AW'($urandom_range(0, 9));
      read_reg_2  = ($urandom_range(0, 3) == 0) ? read_reg_1 : AW'($urandom_range(0, 31));
      check_all("rand");
      tick();
    end

    // Leave some registers pending, then reset at sweep cycle 12.
    reset = 0;
    while (!m_run) tick();
    alloc_valid = 1; alloc_reg = 9; tick();
    regwrite = 1; write_reg = 12; write_data = 32'hCAFE_0012; alloc_reg = 13; tick();
    regwrite = 0; alloc_valid = 0;
    reset = 1; tick();
    reset = 0;
    for (int i = 0; i < 12; i++) tick();
    reset = 1; tick();
    reset = 0;
    for (int i = 0; i < DEPTH; i++) begin
      check("restart_busy", 64'(busy), 64'd1);
      tick();
    end
    check("restart_done", 64'(busy), 64'd0);
    check("restart_pv", 64'(pending_vec), 64'h0);
    for (int i = 0; i < DEPTH; i++) begin
      read_reg_1 = AW'(i);
      read_reg_2 = AW'(DEPTH - 1 - i);
      #1;
      check("index1", 64'(read_data1), 64'(i));
      check("index2", 64'(read_data2), 64'(DEPTH - 1 - i));
      check("ready1", 64'(read_ready1), 64'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the single-cycle RISC-V core, and the successor to the fixed 32×32 file. Width and depth are configurable, and register 0 can optionally be hardwired to zero. A synchronous reset launches a sequential initialisation sweep. A per-register scoreboard tracks in-flight destinations for multi-cycle units. Same-cycle write-to-read forwarding is optional.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/allocs; 0 = register 0 is ordinary

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; restarts the init sweep
- read_reg_1  in  ADDR_W  read port 1 address
- read_data1  out  DATA_W  read port 1 data (combinational)
- read_ready1  out  1  port 1 register not pending
- read_reg_2  in  ADDR_W  read port 2 address
- read_data2  out  DATA_W  read port 2 data (combinational)
- read_ready2  out  1  port 2 register not pending
- write_reg  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- regwrite  in  1  write enable
- alloc_valid  in  1  mark alloc_reg pending
- alloc_reg  in  ADDR_W  destination being allocated
- busy  out  1  init sweep in progress
- pending_vec  out  DEPTH  scoreboard bits, bit i = register i pending

## Operation
- States: INIT, RUN.
- Reset:
  - At each rising edge with reset=1: state<=INIT, sweep counter cnt<=0, all pending bits<=0.
  - Output values while in INIT: busy=1, read_data1/2=0, read_ready1/2=0, pending_vec=0.
- INIT:
  - Each edge with reset=0 writes mem[cnt] <= cnt, zero-extended or truncated to DATA_W, then cnt<=cnt+1.
  - The edge that writes cnt==DEPTH-1 moves the block to RUN.
  - regwrite and alloc_valid are ignored throughout INIT.
- RUN, write:
  - At each edge, if regwrite=1 and (write_reg!=0 or ZERO_REG==0): mem[write_reg]<=write_data and pending[write_reg]<=0.
- RUN, alloc:
  - At each edge, if alloc_valid=1 and (alloc_reg!=0 or ZERO_REG==0): pending[alloc_reg]<=1.
  - Simultaneous write and alloc to the same register: alloc wins, so the pending bit ends at 1 and the data is still written.
- RUN, read:
  - read_dataN = mem[read_reg_N].
  - If ZERO_REG=1 and read_reg_N=0: read_dataN=0 and read_readyN=1.
  - Otherwise read_readyN = ~pending[read_reg_N], subject to the bypass rules under Configuration.
- Boundaries:
  - Both read ports may address the same register; both return identical data.
  - Reset mid-sweep restarts the sweep at cnt=0.
  - Reset in RUN discards all pending bits and re-initialises every register.
- Widths: cnt is ADDR_W+1 bits so the end-of-sweep test is DEPTH-1 exactly; there is no out-of-range address.

## Timing
- Read latency: combinational, 0 cycles.
- A write becomes visible on the read ports after the write edge (next cycle), unless forwarded (see Configuration).
- Pending set or clear is visible on read_readyN and pending_vec after the edge.
- After reset deasserts, busy stays high for exactly DEPTH rising edges and is 0 from the cycle following the DEPTH-th edge. Default: 32 cycles.
- There is no back-pressure; the instruction-fetch stage must stall while busy=1.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, if regwrite=1 with a legal write_reg equal to read_reg_N, then read_dataN=write_data and read_readyN=1 in the same cycle.
  - This applies even if the register is pending, so a multi-cycle unit's writeback unblocks the reader immediately.
- REGFILE_BYPASS_EN undefined:
  - read_dataN shows the old value until the edge.
  - read_readyN follows pending only.
- Register 0 with ZERO_REG=1 is never forwarded in either build.

## Test plan
- Reset for 2 cycles, then release:
  - busy=1 for 32 cycles, then 0.
  - read_reg_1=10 gives read_data1=0x0000000A; read_reg_2=31 gives read_data2=0x0000001F.
- RUN, regwrite=1, write_reg=0, write_data=0xDEADBEEF, ZERO_REG=1: read_data1 at address 0 stays 0 and read_ready1=1.
- RUN, write reg 7 with 0x12345678 while read_reg_1=7:
  - With REGFILE_BYPASS_EN: read_data1=0x12345678 in the same cycle.
  - Without it: read_data1=0x00000007 in the same cycle and 0x12345678 in the next cycle.
- Scoreboard sequence:
  - alloc reg 5 gives read_ready1=0 and pending_vec[5]=1.
  - A later write to reg 5 returns ready to 1.
  - Alloc and write to reg 5 in the same cycle leaves pending_vec[5]=1 and the data updated.
- Reset asserted at sweep cycle 12 for 1 cycle: the sweep restarts, busy stays high a further 32 cycles, all 32 registers hold their index, and pending_vec=0.
- During INIT, regwrite to reg 3 with 0xFFFF and alloc of reg 4 are both ignored: after the sweep, reg 3=0x3 and pending_vec=0.
